// File: rtl/sonic_xgmii_pkg.sv
// Shared XGMII definitions for the loopback controller: lane layout,
// the idle control word, the mode FSM states and an idle-word test.
package sonic_xgmii_pkg;

  localparam int XGMII_LANES  = 8;
  localparam int XGMII_LANE_W = 9;
  localparam int XGMII_W      = XGMII_LANES * XGMII_LANE_W;

  localparam logic [7:0] XGMII_CTRL_IDLE = 8'h07;

  // One idle lane is the control flag set with the /I/ character.
  localparam logic [XGMII_LANE_W-1:0] IDLE_LANE = {1'b1, XGMII_CTRL_IDLE};
  localparam logic [XGMII_W-1:0]      IDLE_WORD = {XGMII_LANES{IDLE_LANE}};

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ARM_LB   = 2'd1,
    LOOPBACK = 2'd2,
    ARM_NORM = 2'd3
  } lb_state_e;

  // A word is idle only when every lane carries a control /I/.
  function automatic logic is_idle_word(input logic [XGMII_W-1:0] word);
    logic idle;
    idle = 1'b1;
    for (int lane = 0; lane < XGMII_LANES; lane++) begin
      if (word[lane*XGMII_LANE_W +: XGMII_LANE_W] != IDLE_LANE) begin
        idle = 1'b0;
      end
    end
    return idle;
  endfunction

endpackage

// File: rtl/sonic_xgmii_idle_det.sv
// Combinational idle detector for one 72-bit XGMII word.
module sonic_xgmii_idle_det
  import sonic_xgmii_pkg::*;
(
  input  logic [XGMII_W-1:0] word,
  output logic               is_idle
);

  // Flag the word as idle when all eight lanes are control /I/.
  always_comb begin
    is_idle = is_idle_word(word);
  end

endmodule

// File: rtl/sonic_eth_loopback_ctrl.sv
// XGMII loopback mode controller. Sits between MAC and PHY and either
// passes both directions straight through or turns MAC TX back into
// MAC RX. Mode changes wait for a run of idle words on both streams so
// no frame is cut, with an optional timeout that forces the change.
module sonic_eth_loopback_ctrl
  import sonic_xgmii_pkg::*;
#(
  parameter int IDLE_RUN       = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lb_enable,
  input  logic [XGMII_W-1:0] tx_in_data,
  input  logic [XGMII_W-1:0] rx_in_data,
  output logic [XGMII_W-1:0] tx_out_data,
  output logic [XGMII_W-1:0] rx_out_data,
  output logic               lb_active,
  output logic               lb_busy,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   switch_count
);

  // The idle run is counted up to IDLE_RUN; a switch is allowed once the
  // current idle word completes the run.
  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(IDLE_RUN);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(IDLE_RUN - 1);

  // A zero timeout disables forced switching entirely.
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int               TO_LAST_I  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TO_LAST_I);

  lb_state_e        state;
  lb_state_e        next_state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_cnt_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             tx_idle;
  logic             rx_idle;
  logic             both_idle;
  logic             in_arm;
  logic             route_lb;
  logic             switch_ok;
  logic             timeout_hit;
  logic             do_switch;
  logic             do_timeout;

  sonic_xgmii_idle_det u_tx_idle (
    .word    (tx_in_data),
    .is_idle (tx_idle)
  );

  sonic_xgmii_idle_det u_rx_idle (
    .word    (rx_in_data),
    .is_idle (rx_idle)
  );

  // Decode the current mode and the switch conditions for this cycle.
  always_comb begin
    both_idle   = tx_idle && rx_idle;
    in_arm      = (state == ARM_LB) || (state == ARM_NORM);
    route_lb    = (state == LOOPBACK) || (state == ARM_NORM);
    switch_ok   = both_idle && (run_cnt >= RUN_LAST);
    timeout_hit = TIMEOUT_EN && (wait_cnt == TO_LAST);
  end

  // Next-state selection: abort beats an idle-run switch, which beats the timeout.
  always_comb begin
    next_state = state;
    do_switch  = 1'b0;
    do_timeout = 1'b0;
    case (state)
      NORMAL: begin
        if (lb_enable) begin
          next_state = ARM_LB;
        end
      end
      ARM_LB: begin
        if (!lb_enable) begin
          next_state = NORMAL;
        end else if (switch_ok) begin
          next_state = LOOPBACK;
          do_switch  = 1'b1;
        end else if (timeout_hit) begin
          next_state = LOOPBACK;
          do_switch  = 1'b1;
          do_timeout = 1'b1;
        end
      end
      LOOPBACK: begin
        if (!lb_enable) begin
          next_state = ARM_NORM;
        end
      end
      ARM_NORM: begin
        if (lb_enable) begin
          next_state = LOOPBACK;
        end else if (switch_ok) begin
          next_state = NORMAL;
          do_switch  = 1'b1;
        end else if (timeout_hit) begin
          next_state = NORMAL;
          do_switch  = 1'b1;
          do_timeout = 1'b1;
        end
      end
      default: begin
        next_state = NORMAL;
      end
    endcase
  end

  // Idle-run and wait counters live only while arming and restart on every state entry.
  always_comb begin
    run_cnt_next  = '0;
    wait_cnt_next = '0;
    if (in_arm && (next_state == state)) begin
      wait_cnt_next = wait_cnt + CNT_W'(1);
      if (both_idle) begin
        run_cnt_next = (run_cnt < RUN_MAX) ? run_cnt + CNT_W'(1) : run_cnt;
      end
    end
  end

  // State, counters and status flags; lb_active trails the state so it lines up with the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= NORMAL;
      run_cnt      <= '0;
      wait_cnt     <= '0;
      lb_active    <= 1'b0;
      timeout_err  <= 1'b0;
      switch_count <= '0;
    end else begin
      state       <= next_state;
      run_cnt     <= run_cnt_next;
      wait_cnt    <= wait_cnt_next;
      lb_active   <= route_lb;
      timeout_err <= do_timeout;
      if (do_switch) begin
        switch_count <= switch_count + CNT_W'(1);
      end
    end
  end

  // Datapath routing follows the current state, so the switching word still goes out the old way.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_out_data <= IDLE_WORD;
      rx_out_data <= IDLE_WORD;
    end else if (route_lb) begin
      tx_out_data <= IDLE_WORD;
      rx_out_data <= tx_in_data;
    end else begin
      tx_out_data <= tx_in_data;
      rx_out_data <= rx_in_data;
    end
  end

  assign lb_busy = in_arm;

endmodule
